lcd_pixel_fetch: RTL
====================

Name: lcd_pixel_fetch

Overview:
- Sits directly downstream of the video timing generator. Consumes its hcnt/vcnt and its blank and sync strobes.
- Generates linear read addresses into the background-artwork ROM and the segment-map ROM.
- Looks up each pixel's segment on/off state and darkens background pixels covered by lit LCD segments.
- Emits RGB with hb/vb/hs/vs delayed to stay pixel-aligned with the RGB.

Parameters:
- HACT, 360, active pixels per line.
- VACT, 240, active lines per frame.
- AW, 17, ROM address width. HACT*VACT = 86400 must be < 2^AW.
- MEM_LAT, 2, ROM read latency in vclk cycles (allowed range 1..4).

Ports:
- vclk  in  1  pixel clock. ce_pix is always 1, so every edge is one pixel.
- rst_n  in  1  asynchronous active-low reset.
- hcnt_in  in  10  horizontal counter, used only for checking.
- vcnt_in  in  10  vertical counter, used only for checking.
- hb_in  in  1  horizontal blank, active high.
- vb_in  in  1  vertical blank, active high.
- hs_in  in  1  horizontal sync, active low.
- vs_in  in  1  vertical sync, active low.
- rom_addr  out  AW  address shared by the background ROM and the segment-map ROM.
- rom_rd  out  1  read strobe.
- bg_data  in  24  background RGB888. Valid MEM_LAT cycles after the rom_addr edge.
- seg_id  in  8  segment-map entry. 0 means no segment. Same latency as bg_data.
- seg_idx  out  8  segment-state RAM address.
- seg_on  in  1  state of segment seg_idx. 1-cycle latency.
- r, g, b  out  8 each  output pixel.
- hb, vb, hs, vs  out  1 each  delayed timing signals.
- frame_err  out  1  sticky frame-geometry error flag.

Behaviour:
- Reset (async, rst_n=0):
  - rom_addr=0, rom_rd=0, seg_idx=0, r=g=b=0.
  - hb=vb=hs=vs=1, matching the timing generator's reset values.
  - frame_err=0.
  - All pipeline and delay registers are cleared: timing delay line to 1, data to 0.
  - Deassertion mid-frame: the address counter resynchronises at the next vb_in=1. Output until then is well-formed but may be spatially offset.
- Address counter (stage 0):
  - While vb_in=1, the counter is cleared to 0.
  - Each edge with hb_in=0 and vb_in=0: rom_addr <= counter, rom_rd <= 1, counter <= counter+1.
  - Otherwise rom_rd <= 0 and rom_addr holds.
  - The counter never wraps within a frame. It saturates at 2^AW-1 and sets frame_err.
- Active flag:
  - act = ~hb_in & ~vb_in is carried through the pipeline with each pixel.
- Data capture:
  - At edge n+MEM_LAT (pixel's address issued at edge n), bg_data and seg_id are registered.
  - seg_idx <= seg_id is driven at the same edge.
- Blend (output edge n+MEM_LAT+1):
  - If the delayed act=0: rgb = 0.
  - Else if registered seg_id != 0 and seg_on=1: each channel = channel>>2 (lit segment is dark). Example: 0xFF -> 0x3F.
  - Else: rgb = bg_data, unchanged.
- Timing delay:
  - hb_in/vb_in/hs_in/vs_in go through MEM_LAT+2 register stages.
  - Input sampled at edge n appears on the outputs at edge n+MEM_LAT+1, aligned with that pixel's rgb.
  - Total latency is fixed at MEM_LAT+1 cycles, with no handshake or stall.
- Geometry check:
  - On a rising edge of vb_in, if counter != HACT*VACT, set frame_err. It is sticky until reset.
  - On each active pixel, if hcnt_in >= HACT or vcnt_in >= VACT, set frame_err.
- Simultaneous events:
  - vb_in rising while hb_in=0: the clear takes priority and no read is issued.
  - The first active pixel after vb_in falls reads address 0.

Test Plan:
- Reset mid-line (rst_n low for 3 cycles at hcnt=100) -> all outputs at their reset values immediately (async). Next frame starts at rom_addr=0 and frame_err stays 0.
- Full frame with standard 480x276 timing, bg_data = {addr[7:0], addr[7:0], addr[7:0]}, seg_id=0 -> rom_rd high exactly 86400 cycles; last rom_addr=86399; rgb equals bg_data 3 cycles after the address (MEM_LAT=2); frame_err=0.
- Latency alignment: hb_in falls at edge n -> hb output falls at edge n+3, and the first non-zero rgb appears on that same edge.
- Segment darken: seg_id=5, seg_on=1, bg=0xFF8040 -> rgb=0x3F2010. seg_on=0 -> 0xFF8040. seg_id=0 with seg_on=1 -> 0xFF8040.
- Blanking: bg_data forced to 0xFFFFFF during hb/vb -> rgb=0 and rom_rd=0 throughout the blank interval.
- Bad geometry: vb_in asserted after 239 lines (86040 pixels) -> frame_err=1 at the vb rise and stays 1 through the following good frame until rst_n=0.

Source files
------------

// File: rtl/lcd_pixel_fetch_if.sv
`default_nettype none
// ============================================================================
// lcd_pixel_fetch_if : timing-in, ROM / segment-state and pixel-out bundle
// Revision 1.0
// ============================================================================
interface lcd_pixel_fetch_if #(
   parameter int AW = 17
);
   logic [9:0]    i_hcnt;
   logic [9:0]    i_vcnt;
   logic          i_hb;
   logic          i_vb;
   logic          i_hs;
   logic          i_vs;
   logic [AW-1:0] o_rom_addr;
   logic          o_rom_rd;
   logic [23:0]   i_bg_data;
   logic [7:0]    i_seg_id;
   logic [7:0]    o_seg_idx;
   logic          i_seg_on;
   logic [7:0]    o_r;
   logic [7:0]    o_g;
   logic [7:0]    o_b;
   logic          o_hb;
   logic          o_vb;
   logic          o_hs;
   logic          o_vs;
   logic          o_frame_err;

   modport master (
      output i_hcnt, i_vcnt, i_hb, i_vb, i_hs, i_vs, i_bg_data, i_seg_id, i_seg_on,
      input  o_rom_addr, o_rom_rd, o_seg_idx, o_r, o_g, o_b,
      input  o_hb, o_vb, o_hs, o_vs, o_frame_err
   );

   modport slave (
      input  i_hcnt, i_vcnt, i_hb, i_vb, i_hs, i_vs, i_bg_data, i_seg_id, i_seg_on,
      output o_rom_addr, o_rom_rd, o_seg_idx, o_r, o_g, o_b,
      output o_hb, o_vb, o_hs, o_vs, o_frame_err
   );
endinterface
`default_nettype wire

// File: rtl/lcd_pixel_fetch.sv
`default_nettype none
// ============================================================================
// lcd_pixel_fetch : ROM address generation, LCD segment darkening, timing realign
// Revision 1.0
// ============================================================================
module lcd_pixel_fetch #(
   parameter int HACT    = 360,
   parameter int VACT    = 240,
   parameter int AW      = 17,
   parameter int MEM_LAT = 2
) (
   input  logic             vclk,
   input  logic             rst_n,
   lcd_pixel_fetch_if.slave bus
);
   localparam logic [9:0]    c_HACT    = 10'(HACT);
   localparam logic [9:0]    c_VACT    = 10'(VACT);
   localparam logic [AW-1:0] c_FRAME   = AW'(HACT * VACT);
   localparam logic [AW-1:0] c_CNT_MAX = '1;
   localparam int            c_DLY     = MEM_LAT + 2;

   logic          w_act;
   logic [23:0]   w_dark;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] r_addr;
   logic          r_rd;
   logic          r_vb_prev;
   logic          r_synced;
   logic          r_err;
   logic [MEM_LAT:0] r_act;
   logic [3:0]    r_tim [c_DLY];
   logic [23:0]   r_bg;
   logic [7:0]    r_sid;
   logic [23:0]   r_rgb;

   assign w_act  = ~bus.i_hb & ~bus.i_vb;
   assign w_dark = {2'b00, r_bg[23:18], 2'b00, r_bg[15:10], 2'b00, r_bg[7:2]};

   // Address counter; the size check only counts once a full vblank has been seen
   // since reset, so a mid-frame reset cannot raise a spurious geometry error.
   always_ff @(posedge vclk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_rd      <= 1'b0;
         r_vb_prev <= 1'b1;
         r_synced  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_vb_prev <= bus.i_vb;
         if (bus.i_vb) begin
            r_cnt    <= '0;
            r_rd     <= 1'b0;
            r_synced <= 1'b1;
            if (!r_vb_prev && r_synced && (r_cnt != c_FRAME)) begin
               r_err <= 1'b1;
            end
         end else if (!bus.i_hb) begin
            r_addr <= r_cnt;
            r_rd   <= 1'b1;
            if (r_cnt == c_CNT_MAX) begin
               r_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            if ((bus.i_hcnt >= c_HACT) || (bus.i_vcnt >= c_VACT)) begin
               r_err <= 1'b1;
            end
         end else begin
            r_rd <= 1'b0;
         end
      end
   end

   // ROM data lands MEM_LAT edges after its address; segment state follows one edge later.
   always_ff @(posedge vclk or negedge rst_n) begin
      if (!rst_n) begin
         r_act <= '0;
         for (int i = 0; i < c_DLY; i++) begin
            r_tim[i] <= 4'hF;
         end
         r_bg  <= '0;
         r_sid <= '0;
         r_rgb <= '0;
      end else begin
         r_act    <= {r_act[MEM_LAT-1:0], w_act};
         r_tim[0] <= {bus.i_hb, bus.i_vb, bus.i_hs, bus.i_vs};
         for (int i = 1; i < c_DLY; i++) begin
            r_tim[i] <= r_tim[i-1];
         end
         r_bg  <= bus.i_bg_data;
         r_sid <= bus.i_seg_id;
         if (!r_act[MEM_LAT]) begin
            r_rgb <= '0;
         end else if ((r_sid != 8'd0) && bus.i_seg_on) begin
            r_rgb <= w_dark;
         end else begin
            r_rgb <= r_bg;
         end
      end
   end

   assign bus.o_rom_addr  = r_addr;
   assign bus.o_rom_rd    = r_rd;
   assign bus.o_seg_idx   = r_sid;
   assign bus.o_r         = r_rgb[23:16];
   assign bus.o_g         = r_rgb[15:8];
   assign bus.o_b         = r_rgb[7:0];
   assign bus.o_hb        = r_tim[c_DLY-1][3];
   assign bus.o_vb        = r_tim[c_DLY-1][2];
   assign bus.o_hs        = r_tim[c_DLY-1][1];
   assign bus.o_vs        = r_tim[c_DLY-1][0];
   assign bus.o_frame_err = r_err;
endmodule
`default_nettype wire
